// File: rtl/issue_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package     : Public_Info
// Description : Shared definitions for the issue scheduler. Holds the one-hot
//               instruction-type codes, the scheduler state encoding and small
//               classification helpers used by the scheduler and its
//               pairing/hazard checker.
// Revision    : 1.0 - initial release
// ============================================================================
package Public_Info;

    // One-hot instruction type codes (10-bit type field)
    localparam logic [9:0] c_type_alu  = 10'h001;
    localparam logic [9:0] c_type_br   = 10'h002;
    localparam logic [9:0] c_type_mul  = 10'h004;
    localparam logic [9:0] c_type_div  = 10'h008;
    localparam logic [9:0] c_type_mem  = 10'h010;
    localparam logic [9:0] c_type_ertn = 10'h020;
    localparam logic [9:0] c_type_csr  = 10'h040;
    localparam logic [9:0] c_type_bar  = 10'h080;

    // Serialising types must issue alone with an empty back end.
    localparam logic [9:0] c_type_ser_mask  = c_type_ertn | c_type_csr | c_type_bar;
    // Types that execute in pipe B.
    localparam logic [9:0] c_type_nalu_mask = c_type_br | c_type_mul | c_type_div | c_type_mem;

    // Scheduler state encoding
    typedef logic [1:0] sched_state_t;
    localparam sched_state_t c_st_run    = 2'd0;
    localparam sched_state_t c_st_drain  = 2'd1;
    localparam sched_state_t c_st_serial = 2'd2;
    localparam sched_state_t c_st_wait   = 2'd3;

    function automatic logic f_is_ser(input logic [9:0] t);
        return |(t & c_type_ser_mask);
    endfunction

    function automatic logic f_is_nalu(input logic [9:0] t);
        return |(t & c_type_nalu_mask);
    endfunction

    function automatic logic f_is_mem(input logic [9:0] t);
        return |(t & c_type_mem);
    endfunction

endpackage
`default_nettype wire

// File: rtl/issue_sched_pair_chk.sv
`default_nettype none
// ============================================================================
// Module      : issue_pair_chk
// Description : Combinational pairing and hazard check for the two oldest
//               Issue_Buffer entries.
//   Inputs  : inst_type0/1, rd0/1, we0/1, rs1_0/rs2_0/rs1_1/rs2_1,
//             ld_v/ld_rd (outstanding load destination)
//   Outputs : dual_ok   - head0 and head1 may issue together
//             head0_blk - head0 reads the outstanding load (load-use bubble)
//             head1_blk - head1 reads the outstanding load
// Revision    : 1.0 - initial release
// ============================================================================
module issue_pair_chk
    import Public_Info::*;
(
    input  logic [9:0] inst_type0,
    input  logic [9:0] inst_type1,
    input  logic [4:0] rd0,
    input  logic [4:0] rd1,
    input  logic       we0,
    input  logic       we1,
    input  logic [4:0] rs1_0,
    input  logic [4:0] rs2_0,
    input  logic [4:0] rs1_1,
    input  logic [4:0] rs2_1,
    input  logic       ld_v,
    input  logic [4:0] ld_rd,
    output logic       dual_ok,
    output logic       head0_blk,
    output logic       head1_blk
);

    logic w_raw;
    logic w_waw;
    logic w_any_ser;
    logic w_both_nalu;

    // r0 is hard-wired zero, so writes to it never create a dependency.
    assign w_raw       = we0 && (rd0 != 5'd0) && ((rd0 == rs1_1) || (rd0 == rs2_1));
    assign w_waw       = we0 && we1 && (rd0 == rd1) && (rd0 != 5'd0);
    assign w_any_ser   = f_is_ser(inst_type0) || f_is_ser(inst_type1);
    // Only one pipe B exists, so two non-ALU ops cannot pair.
    assign w_both_nalu = f_is_nalu(inst_type0) && f_is_nalu(inst_type1);

    // ld_rd is never zero while ld_v is set.
    assign head0_blk = ld_v && ((rs1_0 == ld_rd) || (rs2_0 == ld_rd));
    assign head1_blk = ld_v && ((rs1_1 == ld_rd) || (rs2_1 == ld_rd));

    assign dual_ok = !w_any_ser && !w_both_nalu && !w_raw && !w_waw && !head1_blk;

endmodule
`default_nettype wire

// File: rtl/issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : issue_sched
// Description : Issue scheduler for a two-pipe in-order core. Decides each
//               cycle how many Issue_Buffer head entries are consumed and
//               which pipe each goes to. Serialising instructions (ERTN, CSR,
//               BAR) drain the back end, issue alone, then wait DEPTH_CHK+
//               cycles before normal issue resumes.
//   Ports   : clk, rst (sync, active-high)
//             buf_cnt, inst_type0/1, rd0/1, we0/1, rs1_0/rs2_0/rs1_1/rs2_1
//             stall, flush, pipe_busy
//             pop, issue_a, issue_b, swap, serial
//   Macro   : ISSUE_DUAL_EN - when defined, enables dual issue; otherwise at
//             most one entry is consumed per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_sched
    import Public_Info::*;
#(
    parameter int DEPTH_CHK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] buf_cnt,
    input  logic [9:0] inst_type0,
    input  logic [9:0] inst_type1,
    input  logic [4:0] rd0,
    input  logic [4:0] rd1,
    input  logic       we0,
    input  logic       we1,
    input  logic [4:0] rs1_0,
    input  logic [4:0] rs2_0,
    input  logic [4:0] rs1_1,
    input  logic [4:0] rs2_1,
    input  logic       stall,
    input  logic       flush,
    input  logic       pipe_busy,
    output logic [1:0] pop,
    output logic       issue_a,
    output logic       issue_b,
    output logic       swap,
    output logic       serial
);

    localparam int               CNT_W   = $clog2(DEPTH_CHK + 2);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH_CHK);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_ld_v;
    logic [4:0]       r_ld_rd;

    logic [1:0] w_buf_n;
    logic       w_dual_ok;
    logic       w_head0_blk;
    logic       w_head1_blk;
    logic       w_dual;
    logic       w_unused;
    logic [1:0] w_pop;
    logic       w_h0_nalu;
    logic       w_ld_set;
    logic [4:0] w_ld_rd_nxt;

    // An illegal count of 3 behaves as a full two-entry head.
    assign w_buf_n   = (buf_cnt == 2'd3) ? 2'd2 : buf_cnt;
    assign w_h0_nalu = f_is_nalu(inst_type0);

    issue_pair_chk u_pair_chk (
        .inst_type0 (inst_type0),
        .inst_type1 (inst_type1),
        .rd0        (rd0),
        .rd1        (rd1),
        .we0        (we0),
        .we1        (we1),
        .rs1_0      (rs1_0),
        .rs2_0      (rs2_0),
        .rs1_1      (rs1_1),
        .rs2_1      (rs2_1),
        .ld_v       (r_ld_v),
        .ld_rd      (r_ld_rd),
        .dual_ok    (w_dual_ok),
        .head0_blk  (w_head0_blk),
        .head1_blk  (w_head1_blk)
    );

`ifdef ISSUE_DUAL_EN
    assign w_dual   = w_dual_ok && (w_buf_n == 2'd2);
    // head1 load-use is already folded into dual_ok.
    assign w_unused = w_head1_blk;
`else
    assign w_dual   = 1'b0;
    assign w_unused = w_dual_ok ^ w_head1_blk;
`endif

    // Issue decision and next state; flush and stall freeze issue entirely.
    always_comb begin
        w_pop       = 2'd0;
        w_state_nxt = r_state;
        if (!rst && !flush && !stall) begin
            case (r_state)
                c_st_run: begin
                    if (w_buf_n == 2'd0 || w_head0_blk) begin
                        w_pop = 2'd0;
                    end else if (f_is_ser(inst_type0)) begin
                        if (pipe_busy) begin
                            w_state_nxt = c_st_drain;
                        end else begin
                            w_pop       = 2'd1;
                            w_state_nxt = c_st_wait;
                        end
                    end else begin
                        w_pop = w_dual ? 2'd2 : 2'd1;
                    end
                end
                c_st_drain: begin
                    if (!pipe_busy) begin
                        w_state_nxt = c_st_serial;
                    end
                end
                c_st_serial: begin
                    // Head0 is still the serialising op held back in RUN.
                    if (w_buf_n != 2'd0) begin
                        w_pop       = 2'd1;
                        w_state_nxt = c_st_wait;
                    end else begin
                        w_state_nxt = c_st_run;
                    end
                end
                default: begin
                    if (r_wait_cnt >= c_depth && !pipe_busy) begin
                        w_state_nxt = c_st_run;
                    end
                end
            endcase
        end
    end

    // Track the destination of a load issued this cycle (at most one MEM).
    always_comb begin
        w_ld_set    = 1'b0;
        w_ld_rd_nxt = r_ld_rd;
        if (w_pop != 2'd0 && f_is_mem(inst_type0) && we0 && rd0 != 5'd0) begin
            w_ld_set    = 1'b1;
            w_ld_rd_nxt = rd0;
        end else if (w_pop == 2'd2 && f_is_mem(inst_type1) && we1 && rd1 != 5'd0) begin
            w_ld_set    = 1'b1;
            w_ld_rd_nxt = rd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_run;
            r_wait_cnt <= '0;
            r_ld_v     <= 1'b0;
            r_ld_rd    <= 5'd0;
        end else if (flush) begin
            r_state    <= c_st_run;
            r_wait_cnt <= '0;
            r_ld_v     <= 1'b0;
        end else if (!stall) begin
            r_state <= w_state_nxt;
            // Counter restarts from zero on each entry into WAIT and saturates.
            if (r_state == c_st_wait) begin
                if (r_wait_cnt < c_depth) begin
                    r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                end
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_ld_set) begin
                r_ld_v  <= 1'b1;
                r_ld_rd <= w_ld_rd_nxt;
            end else begin
                r_ld_v  <= 1'b0;
            end
        end
    end

    // Head0 goes to pipe B when non-ALU; a paired head1 takes the other pipe.
    assign pop     = w_pop;
    assign issue_a = (w_pop != 2'd0) && ((w_pop == 2'd2) || !w_h0_nalu);
    assign issue_b = (w_pop == 2'd2) || ((w_pop == 2'd1) && w_h0_nalu);
    assign swap    = (w_pop != 2'd0) && w_h0_nalu;
    assign serial  = !rst && (r_state != c_st_run);

endmodule
`default_nettype wire

// File: tb/tb_issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_sched
// Description : Self-checking bench for issue_sched. An instruction queue
//               stands in for the Issue_Buffer; a behavioural scheduler model
//               predicts pop/issue/swap/serial each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_sched;
    import Public_Info::*;

    localparam int DEPTH = 2;
`ifdef ISSUE_DUAL_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif
    localparam int M_RUN = 0, M_DRAIN = 1, M_SERIAL = 2, M_WAIT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] buf_cnt;
    logic [9:0] inst_type0, inst_type1;
    logic [4:0] rd0, rd1, rs1_0, rs2_0, rs1_1, rs2_1;
    logic       we0, we1, stall, flush, pipe_busy;
    logic [1:0] pop;
    logic       issue_a, issue_b, swap, serial;

    issue_sched #(.DEPTH_CHK(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .buf_cnt    (buf_cnt),
        .inst_type0 (inst_type0),
        .inst_type1 (inst_type1),
        .rd0        (rd0),
        .rd1        (rd1),
        .we0        (we0),
        .we1        (we1),
        .rs1_0      (rs1_0),
        .rs2_0      (rs2_0),
        .rs1_1      (rs1_1),
        .rs2_1      (rs2_1),
        .stall      (stall),
        .flush      (flush),
        .pipe_busy  (pipe_busy),
        .pop        (pop),
        .issue_a    (issue_a),
        .issue_b    (issue_b),
        .swap       (swap),
        .serial     (serial)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] t;
        logic [4:0] rd;
        logic       we;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } inst_t;

    inst_t      q[$];
    int         md;
    int         wcnt;
    bit         ldv;
    logic [4:0] ldrd;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         last_pop;
    int         last_serial;
    int         last_swap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic inst_t mk(input logic [9:0] t, input logic [4:0] rd, input logic we,
                                 input logic [4:0] rs1, input logic [4:0] rs2);
        inst_t i;
        i.t = t; i.rd = rd; i.we = we; i.rs1 = rs1; i.rs2 = rs2;
        return i;
    endfunction

    function automatic inst_t rnd_inst();
        int k;
        logic [9:0] t;
        k = $urandom_range(0, 15);
        case (k)
            7:       t = c_type_br;
            8:       t = c_type_mul;
            9:       t = c_type_div;
            10, 11:  t = c_type_mem;
            12:      t = c_type_ertn;
            13:      t = c_type_csr;
            14:      t = c_type_bar;
            default: t = c_type_alu;
        endcase
        return mk(t, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    endfunction

    function automatic bit is_ser(input inst_t i);
        return (i.t == c_type_ertn) || (i.t == c_type_csr) || (i.t == c_type_bar);
    endfunction

    function automatic bit to_b(input inst_t i);
        return (i.t == c_type_br) || (i.t == c_type_mul) || (i.t == c_type_div) || (i.t == c_type_mem);
    endfunction

    function automatic bit reads(input inst_t i, input logic [4:0] r);
        return (i.rs1 == r) || (i.rs2 == r);
    endfunction

    // Can the two oldest entries go down the pipes together?
    function automatic bit pair_ok(input inst_t a, input inst_t b);
        if (is_ser(a) || is_ser(b)) return 0;
        if (to_b(a) && to_b(b)) return 0;
        if (a.we && a.rd != 0 && reads(b, a.rd)) return 0;
        if (a.we && b.we && a.rd != 0 && a.rd == b.rd) return 0;
        if (ldv && reads(b, ldrd)) return 0;
        return 1;
    endfunction

    // One clock: drive inputs, predict, compare, advance model.
    task automatic step(input bit r, input bit busy, input bit stl, input bit fl, input bit b3);
        inst_t h0, h1;
        int    n, ep, nxt;
        bit    ea, eb, esw, eser, got_ld;
        n  = (q.size() > 2) ? 2 : q.size();
        h0 = (n > 0) ? q[0] : rnd_inst();
        h1 = (n > 1) ? q[1] : rnd_inst();
        rst = r; pipe_busy = busy; stall = stl; flush = fl;
        buf_cnt = (n == 2 && b3) ? 2'd3 : 2'(n);
        inst_type0 = h0.t; rd0 = h0.rd; we0 = h0.we; rs1_0 = h0.rs1; rs2_0 = h0.rs2;
        inst_type1 = h1.t; rd1 = h1.rd; we1 = h1.we; rs1_1 = h1.rs1; rs2_1 = h1.rs2;

        ep  = 0;
        nxt = md;
        if (!r && !fl && !stl) begin
            if (md == M_RUN) begin
                if (n == 0) ep = 0;
                else if (ldv && reads(h0, ldrd)) ep = 0;
                else if (is_ser(h0)) begin
                    if (busy) nxt = M_DRAIN;
                    else begin ep = 1; nxt = M_WAIT; end
                end else ep = (DUAL && n == 2 && pair_ok(h0, h1)) ? 2 : 1;
            end else if (md == M_DRAIN) begin
                if (!busy) nxt = M_SERIAL;
            end else if (md == M_SERIAL) begin
                if (n > 0) begin ep = 1; nxt = M_WAIT; end
                else nxt = M_RUN;
            end else begin
                if (wcnt >= DEPTH && !busy) nxt = M_RUN;
            end
        end
        // Pipe assignment: head0 claims its pipe, head1 takes whichever is free.
        ea = 0; eb = 0; esw = 0;
        if (ep >= 1) begin
            if (to_b(h0)) begin eb = 1; esw = 1; end
            else ea = 1;
        end
        if (ep == 2) begin
            if (ea) eb = 1;
            else ea = 1;
        end
        eser = !r && (md != M_RUN);

        #2;
        chk("pop", pop, ep);
        chk("issue_a", issue_a, ea);
        chk("issue_b", issue_b, eb);
        chk("swap", swap, esw);
        chk("serial", serial, eser);
        last_pop    = pop;
        last_serial = serial;
        last_swap   = swap;

        @(posedge clk);
        #1;
        if (r) begin
            md = M_RUN; wcnt = 0; ldv = 0; ldrd = 0;
        end else if (fl) begin
            md = M_RUN; wcnt = 0; ldv = 0;
        end else if (!stl) begin
            got_ld = 0;
            for (int i = 0; i < ep; i++) begin
                if (q[i].t == c_type_mem && q[i].we && q[i].rd != 0) begin
                    got_ld = 1;
                    ldrd   = q[i].rd;
                end
            end
            ldv  = got_ld;
            wcnt = (md == M_WAIT) ? ((wcnt < DEPTH) ? wcnt + 1 : wcnt) : 0;
            md   = nxt;
            repeat (ep) void'(q.pop_front());
        end
    endtask

    task automatic do_reset();
        q.delete();
        step(1, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; buf_cnt = 0; stall = 0; flush = 0; pipe_busy = 0;
        inst_type0 = c_type_alu; inst_type1 = c_type_alu;
        rd0 = 0; rd1 = 0; we0 = 0; we1 = 0; rs1_0 = 0; rs2_0 = 0; rs1_1 = 0; rs2_1 = 0;
        md = M_RUN; wcnt = 0; ldv = 0; ldrd = 0;
        @(posedge clk);
        #1;

        // Reset with a loaded buffer: all outputs held low.
        q.push_back(mk(c_type_alu, 1, 1, 2, 3));
        q.push_back(mk(c_type_mem, 2, 1, 4, 5));
        repeat (3) step(1, $urandom_range(0, 1), 0, 0, 0);
        q.delete();

        // Two independent ALUs.
        do_reset();
        q.push_back(mk(c_type_alu, 3, 1, 1, 2));
        q.push_back(mk(c_type_alu, 9, 1, 5, 5));
        step(0, 0, 0, 0, 0);
        chk("alu_pair_pop", last_pop, DUAL ? 2 : 1);

        // ALU writes r4, MEM reads r4: split over two cycles, MEM swapped to B.
        do_reset();
        q.push_back(mk(c_type_alu, 4, 1, 1, 2));
        q.push_back(mk(c_type_mem, 6, 1, 4, 0));
        step(0, 0, 0, 0, 0);
        chk("raw_first_pop", last_pop, 1);
        step(0, 0, 0, 0, 0);
        chk("raw_second_swap", last_swap, 1);

        // Load r7 then ALU reading r7: one bubble.
        do_reset();
        q.push_back(mk(c_type_mem, 7, 1, 0, 0));
        q.push_back(mk(c_type_alu, 8, 1, 7, 1));
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("load_use_bubble", last_pop, 0);
        step(0, 0, 0, 0, 0);
        chk("load_use_after", last_pop, 1);

        // CSR with busy back end: drain, serial issue, wait, resume.
        do_reset();
        q.push_back(mk(c_type_csr, 0, 0, 1, 2));
        q.push_back(mk(c_type_alu, 5, 1, 1, 1));
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("csr_serial_pop", last_pop, 1);
        repeat (DEPTH + 1) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("csr_back_run", last_serial, 0);

        // Flush in WAIT coincident with stall, then stalled cycles.
        do_reset();
        q.push_back(mk(c_type_bar, 0, 0, 1, 2));
        q.push_back(mk(c_type_alu, 5, 1, 1, 1));
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        chk("flush_stall_serial", last_serial, 0);
        step(0, 0, 1, 0, 0);

        // Randomised traffic.
        do_reset();
        repeat (3000) begin
            if (q.size() < 6 && $urandom_range(0, 9) < 6) q.push_back(rnd_inst());
            step($urandom_range(0, 99) == 0, $urandom_range(0, 1),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
